// File: rtl/bus_key_sequencer.sv
// Bus-access key sequencer: a run of qualified bus accesses whose address codes match KEY
// unlocks the block; repeated mismatches lock it out until reset.
module bus_key_sequencer #(
    parameter int unsigned                KEY_LEN     = 8,
    parameter int unsigned                CODE_W      = 4,
    parameter logic [KEY_LEN*CODE_W-1:0]  KEY         = 32'h5A3C_9612,
    parameter int unsigned                MAX_FAIL    = 3,
    parameter int unsigned                TIMEOUT     = 16,
    parameter logic [CODE_W-1:0]          RELOCK_CODE = '1,
    localparam int unsigned               SW          = $clog2(KEY_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sser,
    input  logic              ba13,
    input  logic              ba12,
    input  logic [CODE_W-1:0] ba_code,
    input  logic              br_w,
    output logic              unlocked,
    output logic              lockout,
    output logic [SW-1:0]     step,
    output logic [3:0]        fail_cnt
);

    localparam int unsigned IW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] LastStep = SW'(KEY_LEN - 1);

    typedef enum logic [1:0] {StIdle, StMatch, StUnlocked, StLockout} state_e;

    state_e              state_q;
    logic [SW-1:0]       step_q;
    logic [3:0]          fail_q;
    logic                unlocked_q;
    logic                lockout_q;
    logic                qual_q;
    logic [IW-1:0]       idle_q;

    logic                qual;
    logic                access;
    logic [CODE_W-1:0]   key_elem;
    logic                code_hit;
    logic                first_hit;
    logic [3:0]          fail_inc;
    logic [IW-1:0]       idle_inc;

    always_comb begin
        qual      = ~sser & ~ba13 & ba12 & br_w;
        access    = qual & ~qual_q;
        key_elem  = KEY[CODE_W*int'(step_q) +: CODE_W];
        code_hit  = (ba_code == key_elem);
        first_hit = (ba_code == KEY[CODE_W-1:0]);
        fail_inc  = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;
        idle_inc  = idle_q + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            step_q     <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            qual_q     <= 1'b0;
            idle_q     <= '0;
        end else begin
            qual_q <= qual;
            unique case (state_q)
                StIdle, StMatch: begin
                    if (access) begin
                        idle_q <= '0;
                        if (code_hit) begin
                            if (step_q == LastStep) begin
                                state_q    <= StUnlocked;
                                unlocked_q <= 1'b1;
                                step_q     <= '0;
                                fail_q     <= '0;
                            end else begin
                                state_q <= StMatch;
                                step_q  <= step_q + SW'(1);
                            end
                        end else begin
                            fail_q <= fail_inc;
                            // Lockout wins over restarting on element 0.
                            if (fail_inc == 4'(MAX_FAIL)) begin
                                state_q   <= StLockout;
                                lockout_q <= 1'b1;
                                step_q    <= '0;
                            end else if (first_hit) begin
                                state_q <= StMatch;
                                step_q  <= SW'(1);
                            end else begin
                                state_q <= StIdle;
                                step_q  <= '0;
                            end
                        end
                    end else if (state_q == StMatch && TIMEOUT != 0) begin
                        if (idle_inc == IW'(TIMEOUT)) begin
                            state_q <= StIdle;
                            step_q  <= '0;
                            idle_q  <= '0;
                        end else begin
                            idle_q <= idle_inc;
                        end
                    end
                end
                StUnlocked: begin
                    if (access && ba_code == RELOCK_CODE) begin
                        state_q    <= StIdle;
                        unlocked_q <= 1'b0;
                        step_q     <= '0;
                        idle_q     <= '0;
                    end
                end
                StLockout: begin
                    // Sticky until reset.
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign unlocked = unlocked_q;
    assign lockout  = lockout_q;
    assign step     = step_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Directed bench for bus_key_sequencer: default-key instance plus a 4x3-bit key instance.
module tb_bus_key_sequencer;

    logic       clk;
    logic       rst_n;
    logic       sser;
    logic       ba13;
    logic       ba12;
    logic       br_w;
    logic [3:0] code;

    logic       u0, l0;
    logic [3:0] step0;
    logic [3:0] fc0;
    logic       u1, l1;
    logic [2:0] step1;
    logic [3:0] fc1;

    int checks;
    int passes;
    int fails;

    logic [3:0] key8 [8];

    bus_key_sequencer dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sser     (sser),
        .ba13     (ba13),
        .ba12     (ba12),
        .ba_code  (code),
        .br_w     (br_w),
        .unlocked (u0),
        .lockout  (l0),
        .step     (step0),
        .fail_cnt (fc0)
    );

    bus_key_sequencer #(
        .KEY_LEN (4),
        .CODE_W  (3),
        .KEY     (12'o7531)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sser     (sser),
        .ba13     (ba13),
        .ba12     (ba12),
        .ba_code  (code[2:0]),
        .br_w     (br_w),
        .unlocked (u1),
        .lockout  (l1),
        .step     (step1),
        .fail_cnt (fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single-cycle access followed by one gap cycle so the next one is a fresh edge.
    task automatic acc(input logic [3:0] c);
        code = c;
        sser = 1'b0;
        @(negedge clk);
        sser = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        key8   = '{4'h2, 4'h1, 4'h6, 4'h9, 4'hC, 4'h3, 4'hA, 4'h5};
        rst_n  = 1'b0;
        sser   = 1'b1;
        ba13   = 1'b0;
        ba12   = 1'b1;
        br_w   = 1'b1;
        code   = 4'h0;
        idle(2);
        chk("reset_unlocked", {31'd0, u0}, 32'd0);
        chk("reset_lockout", {31'd0, l0}, 32'd0);
        chk("reset_step", {28'd0, step0}, 32'd0);
        chk("reset_fail", {28'd0, fc0}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // ba13 high disqualifies the access
        ba13 = 1'b1;
        acc(4'h2);
        ba13 = 1'b0;
        chk("disq_step", {28'd0, step0}, 32'd0);

        // Full default key
        for (int i = 0; i < 7; i++) begin
            acc(key8[i]);
            chk($sformatf("key_step%0d", i), {28'd0, step0}, 32'(i + 1));
        end
        acc(key8[7]);
        chk("unlock_u", {31'd0, u0}, 32'd1);
        chk("unlock_step", {28'd0, step0}, 32'd0);
        chk("unlock_fail", {28'd0, fc0}, 32'd0);
        acc(4'h2);
        chk("unl_ignore", {31'd0, u0}, 32'd1);
        acc(4'hF);
        chk("relock_u", {31'd0, u0}, 32'd0);
        chk("relock_step", {28'd0, step0}, 32'd0);

        // Mismatch then restart
        acc(4'h2);
        acc(4'h1);
        acc(4'h7);
        chk("mis_step", {28'd0, step0}, 32'd0);
        chk("mis_fail", {28'd0, fc0}, 32'd1);
        acc(4'h2);
        chk("mis2_step", {28'd0, step0}, 32'd1);
        chk("mis2_fail", {28'd0, fc0}, 32'd1);

        // Asynchronous reset clears mid-sequence progress without a clock edge
        #2 rst_n = 1'b0;
        #1 chk("async_step", {28'd0, step0}, 32'd0);
        chk("async_fail", {28'd0, fc0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout boundary: 15 idle cycles keep progress, 16th drops it
        acc(4'h2);
        idle(14);
        chk("to_before", {28'd0, step0}, 32'd1);
        idle(1);
        chk("to_expired", {28'd0, step0}, 32'd0);
        chk("to_fail", {28'd0, fc0}, 32'd0);
        acc(4'h2);
        idle(14);
        acc(4'h1);
        chk("to_access_wins", {28'd0, step0}, 32'd2);
        // Mismatch carrying element 0 restarts at step 1
        acc(4'h2);
        chk("restart_step", {28'd0, step0}, 32'd1);
        chk("restart_fail", {28'd0, fc0}, 32'd1);

        // Held qual counts once
        rst_pulse();
        code = 4'h2;
        sser = 1'b0;
        idle(10);
        sser = 1'b1;
        idle(1);
        chk("held_step", {28'd0, step0}, 32'd1);
        for (int i = 1; i < 8; i++) acc(key8[i]);
        chk("held_unlock", {31'd0, u0}, 32'd1);
        acc(4'hF);
        chk("held_relock", {31'd0, u0}, 32'd0);
        chk("held_relock_step", {28'd0, step0}, 32'd0);

        // Lockout after three mismatches
        rst_pulse();
        acc(4'h0);
        acc(4'h0);
        chk("lo_pre", {31'd0, l0}, 32'd0);
        chk("lo_pre_fail", {28'd0, fc0}, 32'd2);
        acc(4'h0);
        chk("lo_set", {31'd0, l0}, 32'd1);
        chk("lo_fail", {28'd0, fc0}, 32'd3);
        chk("lo_step", {28'd0, step0}, 32'd0);
        for (int i = 0; i < 8; i++) acc(key8[i]);
        chk("lo_key_u", {31'd0, u0}, 32'd0);
        chk("lo_sticky", {31'd0, l0}, 32'd1);
        rst_pulse();
        chk("lo_clear", {31'd0, l0}, 32'd0);
        chk("lo_clear_fail", {28'd0, fc0}, 32'd0);

        // Small instance: KEY_LEN=4, CODE_W=3
        acc(4'h1);
        acc(4'h3);
        acc(4'h5);
        chk("small_step", {29'd0, step1}, 32'd3);
        acc(4'h7);
        chk("small_unlock", {31'd0, u1}, 32'd1);
        acc(4'h7);
        chk("small_relock", {31'd0, u1}, 32'd0);
        acc(4'h1);
        acc(4'h3);
        chk("small_mid", {29'd0, step1}, 32'd2);
        #3 rst_n = 1'b0;
        #1 chk("small_async", {29'd0, step1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
